// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
//   - Default frame geometry (data bits, oversample ratio)
//   - Receive FSM state encoding
//   - Counter width helper
package uart_pkg;

  localparam int unsigned DEF_DATA_BITS  = 8;
  localparam int unsigned DEF_OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    DONE  = 3'd4
  } rx_state_e;

  // Width of a counter spanning 0..n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_sync_maj.sv
// rx synchroniser chain plus 3-tap majority filter.
// Ports:
//   clk, rst   - clock, asynchronous active-low reset
//   tick16     - oversample strobe; advances the majority history
//   rx         - raw asynchronous serial line
//   rxs        - synchronised line (registered)
//   fall_c     - rxs was 1 last clk and is 0 now
//   maj_c      - majority of the two previous tick samples and current rxs
module uart_sync_maj #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic tick16,
  input  logic rx,
  output logic rxs,
  output logic fall_c,
  output logic maj_c
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_rxs_d;
  logic [1:0]             r_hist;

  // Synchroniser chain and one-clk delayed copy for edge detection; reset to idle-high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync  <= '1;
      r_rxs_d <= 1'b1;
    end else begin
      r_sync[0] <= rx;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        r_sync[i] <= r_sync[i-1];
      end
      r_rxs_d <= r_sync[SYNC_STAGES-1];
    end
  end

  // Sample history on each tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hist <= 2'b11;
    end else if (tick16) begin
      r_hist <= {r_hist[0], r_sync[SYNC_STAGES-1]};
    end
  end

  assign rxs    = r_sync[SYNC_STAGES-1];
  assign fall_c = r_rxs_d & ~rxs;
  assign maj_c  = (r_hist[1] & r_hist[0]) | (r_hist[1] & rxs) | (r_hist[0] & rxs);

endmodule

// File: rtl/uart_rx_frontend.sv
// UART receive front end: start-bit detection, mid-bit sampling with 16x
// oversampling, 8N1 frame assembly and a valid/ready byte output.
// Ports:
//   clk, rst   - clock, asynchronous active-low reset
//   tick16     - one-clk strobe at OVERSAMPLE x baud
//   rx         - raw serial line, idle high
//   data       - received byte, stable while valid
//   valid      - byte available until accepted
//   ready      - consumer accepts on valid & ready
//   frame_err  - stop bit sampled low for the byte in data
//   overrun    - sticky: a frame completed while a byte was unaccepted
//   busy       - start-bit detection through the stop-bit sample
module uart_rx_frontend
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS   = DEF_DATA_BITS,
  parameter int unsigned OVERSAMPLE  = DEF_OVERSAMPLE,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick16,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned CNT_W = cnt_width(OVERSAMPLE);
  localparam int unsigned IDX_W = cnt_width(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  rx_state_e            r_state, w_state_nxt;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
  logic [IDX_W-1:0]     r_idx, w_idx_nxt;
  logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
  logic                 r_stop, w_stop_nxt;
  logic                 r_busy, w_busy_nxt;

  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_frame_err;
  logic                 r_overrun;

  logic w_rxs;
  logic w_fall;
  logic w_maj;

  uart_sync_maj #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_maj (
    .clk    (clk),
    .rst    (rst),
    .tick16 (tick16),
    .rx     (rx),
    .rxs    (w_rxs),
    .fall_c (w_fall),
    .maj_c  (w_maj)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and datapath updates; nothing moves outside IDLE/DONE without a tick.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_stop_nxt  = r_stop;
    w_busy_nxt  = r_busy;

    case (r_state)
      IDLE: begin
        if (w_fall) begin
          w_state_nxt = START;
          w_cnt_nxt   = '0;
          w_busy_nxt  = 1'b1;
        end
      end

      START: begin
        if (tick16) begin
          if (r_cnt == CNT_MID) begin
            if (w_maj) begin
              w_state_nxt = IDLE;
              w_busy_nxt  = 1'b0;
            end else begin
              w_state_nxt = DATA;
              w_cnt_nxt   = '0;
              w_idx_nxt   = '0;
            end
          end else begin
            w_cnt_nxt = CNT_W'(r_cnt + 1'b1);
          end
        end
      end

      DATA: begin
        if (tick16) begin
          if (r_cnt == CNT_LAST) begin
            w_cnt_nxt   = '0;
            w_shift_nxt = {w_maj, r_shift[DATA_BITS-1:1]};
            if (r_idx == IDX_LAST) begin
              w_state_nxt = STOP;
            end else begin
              w_idx_nxt = IDX_W'(r_idx + 1'b1);
            end
          end else begin
            w_cnt_nxt = CNT_W'(r_cnt + 1'b1);
          end
        end
      end

      STOP: begin
        if (tick16) begin
          if (r_cnt == CNT_LAST) begin
            w_cnt_nxt   = '0;
            w_stop_nxt  = w_maj;
            w_state_nxt = DONE;
            w_busy_nxt  = 1'b0;
          end else begin
            w_cnt_nxt = CNT_W'(r_cnt + 1'b1);
          end
        end
      end

      DONE: begin
        w_state_nxt = IDLE;
      end

      default: begin
        w_state_nxt = IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // Counters, shift register and stop sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_stop  <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
      r_stop  <= w_stop_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  // Output register: a completed frame loads only if the slot is free or being freed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else if (r_state == DONE) begin
      if (!r_valid || ready) begin
        r_data      <= r_shift;
        r_frame_err <= ~r_stop;
        r_valid     <= 1'b1;
      end else begin
        r_overrun <= 1'b1;
      end
    end else if (r_valid && ready) begin
      r_valid <= 1'b0;
    end
  end

  assign data      = r_data;
  assign valid     = r_valid;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;
  assign busy      = r_busy;

endmodule
